// File: rtl/aes_stream_ctrl_pkg.sv
// Shared constants, FSM state type and byte-swap helper for the AES stream sequencer.
package aes_ctrl_pkg;

    localparam int WORD_S        = 32;
    localparam int BLK_S         = 128;
    localparam int KEY_S         = 128;
    localparam int WORDS_PER_BLK = BLK_S / WORD_S;

    localparam logic [7:0] CMD_ENCRYPT = 8'h10;
    localparam logic [7:0] CMD_SET_KEY = 8'h20;
    localparam logic [7:0] CMD_DECRYPT = 8'h30;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_DRAIN,
        ST_EXEC,
        ST_WAIT_KEY,
        ST_WAIT_BLK,
        ST_SEND
    } state_t;

    function automatic logic [31:0] swap_bytes32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic opcode_valid(input logic [7:0] op);
        return (op == CMD_ENCRYPT) || (op == CMD_DECRYPT) || (op == CMD_SET_KEY);
    endfunction

endpackage

// File: rtl/aes_stream_ctrl_if.sv
// 32-bit stream beat bundle; master drives data/valid/last, slave drives ready.
interface aes_stream_ctrl_if;
    import aes_ctrl_pkg::*;

    logic [WORD_S-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/aes_stream_ctrl_word_packer.sv
// Gathers four little-endian beats into a big-endian block and serialises a result block back out.
// Beat 0 carries the most significant word in both directions; output beat advances only on out_adv.
module aes_word_packer
    import aes_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_vld,
    input  logic [WORD_S-1:0] in_word,
    output logic [BLK_S-1:0]  blk_next,
    output logic [1:0]        in_cnt,
    output logic              full,
    input  logic              res_load,
    input  logic [BLK_S-1:0]  res_in,
    input  logic              out_adv,
    output logic [WORD_S-1:0] out_word,
    output logic              out_last
);

    logic [BLK_S-1:0] blk_q;
    logic [BLK_S-1:0] res_q;
    logic [1:0]       out_cnt;

    // blk_next is exposed so the engine register can load in the same cycle as the last beat.
    always_comb begin
        blk_next = blk_q;
        if (in_vld) begin
            case (in_cnt)
                2'd0: blk_next[127:96] = swap_bytes32(in_word);
                2'd1: blk_next[95:64]  = swap_bytes32(in_word);
                2'd2: blk_next[63:32]  = swap_bytes32(in_word);
                2'd3: blk_next[31:0]   = swap_bytes32(in_word);
            endcase
        end
    end

    always_comb begin
        out_word = '0;
        case (out_cnt)
            2'd0: out_word = swap_bytes32(res_q[127:96]);
            2'd1: out_word = swap_bytes32(res_q[95:64]);
            2'd2: out_word = swap_bytes32(res_q[63:32]);
            2'd3: out_word = swap_bytes32(res_q[31:0]);
        endcase
    end

    assign out_last = (out_cnt == 2'(WORDS_PER_BLK - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            blk_q   <= '0;
            in_cnt  <= 2'd0;
            full    <= 1'b0;
            res_q   <= '0;
            out_cnt <= 2'd0;
        end else begin
            if (clear) begin
                in_cnt <= 2'd0;
                full   <= 1'b0;
            end else if (in_vld) begin
                blk_q  <= blk_next;
                in_cnt <= in_cnt + 2'd1;
                if (in_cnt == 2'(WORDS_PER_BLK - 1))
                    full <= 1'b1;
            end
            if (res_load) begin
                res_q   <= res_in;
                out_cnt <= 2'd0;
            end else if (out_adv) begin
                out_cnt <= out_cnt + 2'd1;
            end
        end
    end

endmodule

// File: rtl/aes_stream_ctrl.sv
// Command sequencer: parses stream packets, drives AES key-load/start, returns 4-beat responses.
// Engine pulse one cycle after the 4th payload beat; input stalls (tready=0) from EXEC through SEND.
module aes_stream_ctrl
    import aes_ctrl_pkg::*;
(
    input  logic              aclk,
    input  logic              reset,
    aes_stream_ctrl_if.slave  s_axis,
    aes_stream_ctrl_if.master m_axis,
    output logic [KEY_S-1:0]  aes_key,
    output logic              aes_key_load,
    input  logic              aes_key_done,
    output logic [BLK_S-1:0]  aes_blk_in,
    output logic              aes_decrypt,
    output logic              aes_start,
    input  logic              aes_done,
    input  logic [BLK_S-1:0]  aes_blk_out,
    output logic              err
);

    state_t           state_q, state_d;
    logic [7:0]       opcode_q;
    logic             tready_c, tvalid_c, tlast_c;
    logic             in_hs, beat4, err_set, enter_exec;
    logic             pk_clear, pk_in_vld, res_load, out_adv, out_last, full;
    logic [1:0]       in_cnt;
    logic [BLK_S-1:0] blk_next, res_in;
    logic [WORD_S-1:0] out_word;

    assign in_hs      = s_axis.tvalid & tready_c;
    assign beat4      = (in_cnt == 2'(WORDS_PER_BLK - 1));
    assign enter_exec = (state_q != ST_EXEC) && (state_d == ST_EXEC);

    assign s_axis.tready = tready_c;
    assign m_axis.tvalid = tvalid_c;
    assign m_axis.tlast  = tlast_c;
    assign m_axis.tdata  = out_word;

    always_ff @(posedge aclk) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_hs) begin
                    if (opcode_valid(s_axis.tdata[7:0]) && !s_axis.tlast)
                        state_d = ST_RECV;
                    else if (!s_axis.tlast)
                        state_d = ST_DRAIN;
                end
            end
            ST_RECV: begin
                if (in_hs) begin
                    if (s_axis.tlast)
                        state_d = beat4 ? ST_EXEC : ST_IDLE;
                    else if (beat4)
                        state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (in_hs && s_axis.tlast)
                    state_d = full ? ST_EXEC : ST_IDLE;
            end
            ST_EXEC:     state_d = (opcode_q == CMD_SET_KEY) ? ST_WAIT_KEY : ST_WAIT_BLK;
            ST_WAIT_KEY: if (aes_key_done) state_d = ST_SEND;
            ST_WAIT_BLK: if (aes_done) state_d = ST_SEND;
            ST_SEND:     if (out_adv && out_last) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // tready is gated by reset so no beat is accepted while reset is held.
    always_comb begin
        tready_c     = 1'b0;
        tvalid_c     = 1'b0;
        tlast_c      = 1'b0;
        aes_key_load = 1'b0;
        aes_start    = 1'b0;
        pk_clear     = 1'b0;
        pk_in_vld    = 1'b0;
        res_load     = 1'b0;
        res_in       = '0;
        out_adv      = 1'b0;
        err_set      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tready_c = ~reset;
                pk_clear = in_hs;
                err_set  = in_hs && (!opcode_valid(s_axis.tdata[7:0]) || s_axis.tlast);
            end
            ST_RECV: begin
                tready_c  = ~reset;
                pk_in_vld = in_hs;
                err_set   = in_hs && (s_axis.tlast != beat4);
            end
            ST_DRAIN: tready_c = ~reset;
            ST_EXEC: begin
                if (opcode_q == CMD_SET_KEY)
                    aes_key_load = 1'b1;
                else
                    aes_start = 1'b1;
            end
            ST_WAIT_KEY: res_load = aes_key_done;
            ST_WAIT_BLK: begin
                res_load = aes_done;
                res_in   = aes_blk_out;
            end
            ST_SEND: begin
                tvalid_c = 1'b1;
                tlast_c  = out_last;
                out_adv  = m_axis.tready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            opcode_q    <= 8'h00;
            err         <= 1'b0;
            aes_key     <= '0;
            aes_blk_in  <= '0;
            aes_decrypt <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && in_hs)
                opcode_q <= s_axis.tdata[7:0];
            if (err_set)
                err <= 1'b1;
            if (enter_exec) begin
                if (opcode_q == CMD_SET_KEY) begin
                    aes_key <= blk_next;
                end else begin
                    aes_blk_in  <= blk_next;
                    aes_decrypt <= (opcode_q == CMD_DECRYPT);
                end
            end
        end
    end

    aes_word_packer u_packer (
        .clk      (aclk),
        .reset    (reset),
        .clear    (pk_clear),
        .in_vld   (pk_in_vld),
        .in_word  (s_axis.tdata),
        .blk_next (blk_next),
        .in_cnt   (in_cnt),
        .full     (full),
        .res_load (res_load),
        .res_in   (res_in),
        .out_adv  (out_adv),
        .out_word (out_word),
        .out_last (out_last)
    );

endmodule
